// File: rtl/serial_arith_pkg.sv
// -----------------------------------------------------------------------------
// serial_arith_pkg
//   Shared definitions for the bit-serial arithmetic unit: the FSM state
//   encoding and the default operand width.
//   No ports (package).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package serial_arith_pkg;

   // Controller states of the serial adder/subtractor
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   // Default operand/result width
   localparam int DEFAULT_WIDTH = 8;

endpackage : serial_arith_pkg

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   1-bit full adder cell.
//   Ports:
//     in1, in2 : addend bits
//     cin      : carry in
//     out      : sum bit
//     cout     : carry out
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module full_adder (
   input  logic in1,
   input  logic in2,
   input  logic cin,
   output logic out,
   output logic cout
);

   // Sum and majority-carry
   always_comb begin
      out  = in1 ^ in2 ^ cin;
      cout = (in1 & in2) | (in1 & cin) | (in2 & cin);
   end

endmodule : full_adder

// File: rtl/serial_add_sub.sv
// -----------------------------------------------------------------------------
// serial_add_sub
//   Bit-serial two's-complement adder/subtractor. Operands are captured on an
//   accepted start and processed one bit per clock, LSB first, through a
//   single full_adder cell. Subtraction is a + ~b + 1 (carry-in = 1).
//   Ports:
//     clk       : clock, rising edge
//     rst_n     : synchronous active-low reset
//     start     : request, sampled only while idle
//     sub       : 0 = a+b, 1 = a-b (sampled with start)
//     a, b      : WIDTH-bit operands (sampled with start)
//     busy      : high while shifting and in the done cycle
//     done      : one-cycle pulse, result/cout/overflow valid
//     result    : sum/difference, held until the next accepted start
//     cout      : final carry (for sub: 1 = no borrow)
//     overflow  : signed overflow
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module serial_add_sub
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_e           state_q,    state_d;
   logic [WIDTH-1:0] a_sh_q,     a_sh_d;
   logic [WIDTH-1:0] b_sh_q,     b_sh_d;
   logic             carry_q,    carry_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;
   logic [WIDTH-1:0] result_q,   result_d;
   logic             cout_q,     cout_d;
   logic             overflow_q, overflow_d;
   logic             busy_q,     busy_d;
   logic             done_q,     done_d;

   logic             fa_s;
   logic             fa_c;

   full_adder u_fa (
      .in1  (a_sh_q[0]),
      .in2  (b_sh_q[0]),
      .cin  (carry_q),
      .out  (fa_s),
      .cout (fa_c)
   );

   // Next-state, datapath and registered-output decode
   always_comb begin
      state_d    = state_q;
      a_sh_d     = a_sh_q;
      b_sh_d     = b_sh_q;
      carry_d    = carry_q;
      cnt_d      = cnt_q;
      result_d   = result_q;
      cout_d     = cout_q;
      overflow_d = overflow_q;
      busy_d     = busy_q;
      done_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               // Subtraction: invert b and inject the +1 through the carry-in
               a_sh_d  = a;
               b_sh_d  = sub ? ~b : b;
               carry_d = sub;
               cnt_d   = {CNT_W{1'b0}};
               busy_d  = 1'b1;
               state_d = S_SHIFT;
            end else begin
               busy_d  = 1'b0;
            end
         end
         S_SHIFT: begin
            a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
            // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts
            result_d = {fa_s, result_q[WIDTH-1:1]};
            carry_d  = fa_c;
            if (cnt_q == CNT_LAST) begin
               // carry_q here is the carry into the MSB
               cout_d     = fa_c;
               overflow_d = carry_q ^ fa_c;
               done_d     = 1'b1;
               state_d    = S_DONE;
            end else begin
               cnt_d      = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         a_sh_q     <= {WIDTH{1'b0}};
         b_sh_q     <= {WIDTH{1'b0}};
         carry_q    <= 1'b0;
         cnt_q      <= {CNT_W{1'b0}};
         result_q   <= {WIDTH{1'b0}};
         cout_q     <= 1'b0;
         overflow_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_sh_q     <= a_sh_d;
         b_sh_q     <= b_sh_d;
         carry_q    <= carry_d;
         cnt_q      <= cnt_d;
         result_q   <= result_d;
         cout_q     <= cout_d;
         overflow_q <= overflow_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign result   = result_q;
   assign cout     = cout_q;
   assign overflow = overflow_q;

endmodule : serial_add_sub
